// File: rtl/rim_bin_loader.sv
// rim_bin_loader: BIN-format paper-tape loader. Decodes UART tape frames into
// 12-bit RAM writes, holds the last word back as the checksum candidate.
`default_nettype none

module rim_bin_loader (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        EN,
    input  logic [7:0]  RXDATA,
    input  logic        RXVALID,
    output logic [11:0] ADDR,
    output logic [11:0] DATA,
    output logic        WE,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEADER = 3'd1,
        S_HI     = 3'd2,
        S_LO     = 3'd3,
        S_END    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        comment_q, comment_d;
    logic [11:0] sum_q, sum_d;
    logic [11:0] presum_q, presum_d;
    logic [5:0]  hi_q, hi_d;
    logic        hi_org_q, hi_org_d;
    logic        pend_q, pend_d;
    logic [11:0] pend_word_q, pend_word_d;
    logic [11:0] pend_sum_q, pend_sum_d;
    logic [11:0] addr_q, addr_d;
    logic [11:0] naddr_q, naddr_d;
    logic [11:0] data_q, data_d;
    logic        we_q, we_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        w_leader, w_rubout, w_word_frame;
    logic [11:0] w_word;

    assign w_leader     = (RXDATA == 8'o200);
    assign w_rubout     = (RXDATA == 8'o377);
    assign w_word_frame = (RXDATA[7] == 1'b0);
    assign w_word       = {hi_q, RXDATA[5:0]};

    always_comb begin
        state_d     = state_q;
        comment_d   = comment_q;
        sum_d       = sum_q;
        presum_d    = presum_q;
        hi_d        = hi_q;
        hi_org_d    = hi_org_q;
        pend_d      = pend_q;
        pend_word_d = pend_word_q;
        pend_sum_d  = pend_sum_q;
        addr_d      = addr_q;
        naddr_d     = naddr_q;
        data_d      = data_q;
        we_d        = 1'b0;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;

        // Address advances (or takes a deferred origin) in the write cycle itself.
        if (we_q) begin
            addr_d = naddr_q;
        end

        if (!EN) begin
            state_d   = S_IDLE;
            comment_d = 1'b0;
            sum_d     = '0;
            pend_d    = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b0;
        end else if (RXVALID) begin
            case (state_q)
                S_IDLE: begin
                    if (w_leader) begin
                        state_d   = S_LEADER;
                        busy_d    = 1'b1;
                        comment_d = 1'b0;
                        sum_d     = '0;
                        pend_d    = 1'b0;
                    end
                end
                S_LEADER, S_HI, S_LO: begin
                    if (w_rubout) begin
                        comment_d = ~comment_q;
                    end else if (comment_q) begin
                        comment_d = comment_q;
                    end else if (w_word_frame) begin
                        sum_d = sum_q + {4'b0000, RXDATA};
                        if (state_q == S_LO) begin
                            state_d = S_HI;
                            if (pend_q) begin
                                we_d    = 1'b1;
                                data_d  = pend_word_q;
                                naddr_d = hi_org_q ? w_word : addr_q + 12'd1;
                            end else if (hi_org_q) begin
                                addr_d = w_word;
                            end
                            pend_d      = ~hi_org_q;
                            pend_word_d = w_word;
                            pend_sum_d  = presum_q;
                        end else begin
                            state_d  = S_LO;
                            hi_d     = RXDATA[5:0];
                            hi_org_d = RXDATA[6];
                            presum_d = sum_q;
                        end
                    end else if (w_leader && state_q != S_LEADER) begin
                        // Trailer: the held-back word is the checksum; a half word is always an error.
                        state_d = S_END;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        err_d   = (state_q == S_LO) || !pend_q || (pend_word_q != pend_sum_q);
                    end
                end
                S_END: begin
                    state_d = S_END;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            comment_q   <= 1'b0;
            sum_q       <= '0;
            presum_q    <= '0;
            hi_q        <= '0;
            hi_org_q    <= 1'b0;
            pend_q      <= 1'b0;
            pend_word_q <= '0;
            pend_sum_q  <= '0;
            addr_q      <= '0;
            naddr_q     <= '0;
            data_q      <= '0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            comment_q   <= comment_d;
            sum_q       <= sum_d;
            presum_q    <= presum_d;
            hi_q        <= hi_d;
            hi_org_q    <= hi_org_d;
            pend_q      <= pend_d;
            pend_word_q <= pend_word_d;
            pend_sum_q  <= pend_sum_d;
            addr_q      <= addr_d;
            naddr_q     <= naddr_d;
            data_q      <= data_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign ADDR = addr_q;
    assign DATA = data_q;
    assign WE   = we_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign ERR  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_rim_bin_loader.sv
// tb_rim_bin_loader: directed tapes plus random tapes checked against a
// word-level model of the BIN tape format.
`default_nettype none

module tb_rim_bin_loader;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        EN = 1'b0;
    logic [7:0]  RXDATA = 8'h00;
    logic        RXVALID = 1'b0;
    logic [11:0] ADDR, DATA;
    logic        WE, BUSY, DONE, ERR;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tape[$];
    logic [23:0] wq[$];
    logic [23:0] exp_q[$];
    logic        exp_err, exp_done;
    logic [11:0] exp_addr;
    logic [11:0] m_addr = 12'o0;
    logic [11:0] gen_cs;

    rim_bin_loader dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .RXDATA(RXDATA), .RXVALID(RXVALID),
        .ADDR(ADDR), .DATA(DATA), .WE(WE), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (WE === 1'b1) wq.push_back({ADDR, DATA});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] get_w(input int i);
        if (i < wq.size()) return wq[i];
        return 24'hxxxxxx;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            RXVALID = 1'b0;
            RXDATA  = 8'($urandom);
        end
    endtask

    task automatic send_tape(input int maxgap);
        foreach (tape[i]) begin
            @(negedge CLK);
            RXDATA  = tape[i];
            RXVALID = 1'b1;
            idle($urandom_range(0, maxgap));
        end
        idle(1);
    endtask

    // Tape -> words -> writes/checksum, assuming EN held high for the whole tape.
    task automatic run_model();
        logic [7:0]  v[$];
        logic        cmt, started, ended, prev_org, org;
        logic [11:0] addr, sum, presum, word, prev_word;
        int          n;
        cmt = 0; started = 0; ended = 0;
        exp_q.delete();
        foreach (tape[i]) begin
            if (ended) continue;
            if (!started) begin
                if (tape[i] == 8'o200) started = 1;
                continue;
            end
            if (tape[i] == 8'o377) begin cmt = !cmt; continue; end
            if (cmt) continue;
            if (tape[i] == 8'o200) begin
                if (v.size() > 0) ended = 1;
                continue;
            end
            if (tape[i][7] == 1'b0) v.push_back(tape[i]);
        end
        n = v.size() / 2;
        addr = m_addr; sum = 0; presum = 0; prev_org = 1; prev_word = 0;
        for (int k = 0; k < n; k++) begin
            word = {v[2*k][5:0], v[2*k+1][5:0]};
            org  = v[2*k][6];
            if (k > 0 && !prev_org) begin
                exp_q.push_back({addr, prev_word});
                addr = addr + 12'd1;
            end
            if (org) addr = word;
            presum = sum;
            sum = sum + 12'(v[2*k]) + 12'(v[2*k+1]);
            prev_org = org; prev_word = word;
        end
        exp_done = ended;
        exp_addr = addr;
        exp_err  = (v.size() % 2 == 1) || (n == 0) || prev_org || (prev_word != presum);
    endtask

    task automatic junk();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) tape.push_back(8'o300 + 8'($urandom_range(0, 62)));
        if (r == 1) begin
            tape.push_back(8'o377);
            repeat ($urandom_range(1, 3)) tape.push_back(8'($urandom_range(0, 254)));
            tape.push_back(8'o377);
        end
    endtask

    task automatic push_word(input logic org, input logic [11:0] w);
        logic [7:0] hi, lo;
        hi = {1'b0, org, w[11:6]};
        lo = {1'b0, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, w[5:0]};
        junk();
        tape.push_back(hi);
        junk();
        tape.push_back(lo);
        gen_cs = gen_cs + 12'(hi) + 12'(lo);
    endtask

    task automatic gen_tape();
        logic [11:0] cs;
        tape.delete();
        gen_cs = 0;
        repeat ($urandom_range(1, 3)) tape.push_back(8'o200);
        if ($urandom_range(0, 5) != 0)
            push_word(1'b1, ($urandom_range(0, 3) == 0) ? 12'o7776 : 12'($urandom));
        repeat ($urandom_range(1, 4)) begin
            push_word(1'b0, 12'($urandom));
            if ($urandom_range(0, 7) == 0) push_word(1'b1, 12'($urandom));
        end
        if ($urandom_range(0, 7) == 0) begin
            tape.push_back({2'b00, 6'($urandom)});
        end else begin
            cs = gen_cs;
            if ($urandom_range(0, 2) == 0) cs = cs ^ 12'd1;
            push_word(1'b0, cs);
        end
        tape.push_back(8'o200);
        repeat ($urandom_range(0, 2)) tape.push_back(8'($urandom));
    endtask

    task automatic check_model(input string tag);
        check({tag, "_wcount"}, wq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) check({tag, "_write"}, get_w(i), exp_q[i]);
        check({tag, "_done"}, DONE, exp_done);
        check({tag, "_err"},  ERR,  exp_err);
        check({tag, "_busy"}, BUSY, 1'b0);
        check({tag, "_addr"}, ADDR, exp_addr);
    endtask

    task automatic restart();
        @(negedge CLK);
        EN = 1'b0;
        idle(2);
        EN = 1'b1;
        wq.delete();
        m_addr = ADDR === exp_addr ? exp_addr : exp_addr;
    endtask

    task automatic check_basic(input string tag, input logic err);
        check({tag, "_wcount"}, wq.size(), 2);
        check({tag, "_w0"}, get_w(0), {12'o0100, 12'o1234});
        check({tag, "_w1"}, get_w(1), {12'o0101, 12'o5670});
        check({tag, "_done"}, DONE, 1'b1);
        check({tag, "_err"},  ERR,  err);
        check({tag, "_addr"}, ADDR, 12'o0102);
    endtask

    initial begin
        #1 RESET = 1'b0;
        #1;
        check("rst_addr", ADDR, 12'o0);
        check("rst_data", DATA, 12'o0);
        check("rst_flags", {WE, BUSY, DONE, ERR}, 4'b0000);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        EN = 1'b1;

        // Basic tape.
        tape = '{8'o200, 8'o200, 8'o101, 8'o000, 8'o012, 8'o034, 8'o056, 8'o070, 8'o003, 8'o015, 8'o200};
        run_model(); send_tape(0); idle(4);
        check_basic("basic", 1'b0);
        check_model("basic_m");
        restart();

        // Bad checksum.
        tape = '{8'o200, 8'o200, 8'o101, 8'o000, 8'o012, 8'o034, 8'o056, 8'o070, 8'o003, 8'o016, 8'o200};
        run_model(); send_tape(1); idle(4);
        check_basic("badsum", 1'b1);
        restart();

        // Comment and field frames are transparent.
        tape = '{8'o200, 8'o200, 8'o101, 8'o000, 8'o012, 8'o034, 8'o377, 8'o101, 8'o377, 8'o310,
                 8'o056, 8'o070, 8'o003, 8'o015, 8'o200};
        run_model(); send_tape(0); idle(4);
        check_basic("comment", 1'b0);
        restart();

        // Address wrap from 7777.
        tape = '{8'o200, 8'o200, 8'o177, 8'o077, 8'o011, 8'o011, 8'o022, 8'o022, 8'o003, 8'o064, 8'o200};
        run_model(); send_tape(0); idle(4);
        check("wrap_w0", get_w(0), {12'o7777, 12'o1111});
        check("wrap_w1", get_w(1), {12'o0000, 12'o2222});
        check("wrap_flags", {DONE, ERR}, 2'b10);
        check_model("wrap_m");
        restart();

        // Abort mid-load, then a frame while disarmed, then a fresh tape.
        tape = '{8'o200, 8'o200, 8'o101, 8'o000, 8'o012, 8'o034, 8'o056};
        run_model(); send_tape(0); idle(1);
        check("abort_busy_before", BUSY, 1'b1);
        EN = 1'b0;
        idle(3);
        check("abort_wcount", wq.size(), 0);
        check("abort_flags", {BUSY, DONE, ERR}, 3'b000);
        tape = '{8'o200};
        send_tape(0); idle(2);
        check("disarmed_busy", BUSY, 1'b0);
        m_addr = exp_addr;
        EN = 1'b1;
        tape = '{8'o200, 8'o200, 8'o101, 8'o000, 8'o012, 8'o034, 8'o056, 8'o070, 8'o003, 8'o015, 8'o200};
        run_model(); send_tape(2); idle(4);
        check_basic("reload", 1'b0);
        restart();

        // Reset pulse while the completing low frame is on the bus.
        tape = '{8'o200, 8'o101, 8'o000, 8'o012, 8'o034, 8'o056};
        send_tape(0);
        wq.delete();
        @(negedge CLK);
        RXDATA = 8'o070; RXVALID = 1'b1;
        #2 RESET = 1'b0;
        #1;
        check("midrst_addr", ADDR, 12'o0);
        check("midrst_data", DATA, 12'o0);
        check("midrst_flags", {WE, BUSY, DONE, ERR}, 4'b0000);
        idle(2);
        RESET = 1'b1;
        idle(3);
        check("midrst_nowe", wq.size(), 0);
        check("midrst_busy", BUSY, 1'b0);
        m_addr = 12'o0;
        exp_addr = 12'o0;
        restart();

        // Random tapes.
        for (int t = 0; t < 14; t++) begin
            gen_tape();
            run_model();
            send_tape(2);
            idle(4);
            check_model("rand");
            restart();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
